// File: rtl/flex_clk_divider.sv
// Programmable 50%-duty clock divider: slow_clock half-period is m+1 input
// cycles, with a one-cycle tick on every slow_clock edge.
module flex_clk_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             basys_clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m,
  output logic             slow_clock,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic             wrap;

  // >= rather than == so a reduced m mid-count wraps at once instead of
  // letting the counter run on through 2^WIDTH.
  always_comb begin
    wrap = (count >= m);
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      slow_clock <= 1'b0;
      tick       <= 1'b0;
    end else if (wrap) begin
      count      <= '0;
      slow_clock <= ~slow_clock;
      tick       <= 1'b1;
    end else begin
      count      <= count + WIDTH'(1);
      tick       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flex_clk_divider.sv
// Self-checking bench for flex_clk_divider: expected slow_clock/tick per edge
// are derived from the toggle schedule and queued, then popped after each edge.
module tb_flex_clk_divider;

  logic        clk;
  logic        rst_n;
  logic [31:0] m;
  logic        slow_clock;
  logic        tick;

  typedef struct {
    logic slow;
    logic tck;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks;
  int unsigned n_fail;

  flex_clk_divider #(.WIDTH(32)) dut (
    .basys_clock (clk),
    .rst_n       (rst_n),
    .m           (m),
    .slow_clock  (slow_clock),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (slow_clock !== 1'b0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: slow=%b tick=%b, required 0 0", slow_clock, tick);
    end
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (slow_clock !== 1'b0 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: slow=%b tick=%b, required 0 0", i, slow_clock, tick);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fixed-m run from reset release: edge e toggles when e is a multiple of m+1.
  task automatic check_pattern(input string name, input int unsigned mval,
                               input int unsigned edges);
    exp_t e;
    for (int unsigned k = 1; k <= edges; k++) begin
      e.slow = ((k / (mval + 1)) % 2) == 1;
      e.tck  = (k % (mval + 1)) == 0;
      sb.push_back(e);
    end
    for (int unsigned k = 1; k <= edges; k++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (slow_clock !== e.slow || tick !== e.tck) begin
        n_fail++;
        $display("FAIL %s edge%0d: slow=%b tick=%b, required %b %b",
                 name, k, slow_clock, tick, e.slow, e.tck);
      end
    end
  endtask

  // Run with m switched at given edges; toggles listed explicitly.
  task automatic check_schedule(input string name, input int unsigned edges,
                                input int unsigned toggles[$],
                                input int unsigned sw_edge[$],
                                input logic [31:0] sw_m[$]);
    exp_t e;
    int unsigned nt;
    for (int unsigned k = 1; k <= edges; k++) begin
      nt = 0;
      e.tck = 1'b0;
      foreach (toggles[i]) begin
        if (toggles[i] <= k) nt++;
        if (toggles[i] == k) e.tck = 1'b1;
      end
      e.slow = (nt % 2) == 1;
      sb.push_back(e);
    end
    for (int unsigned k = 1; k <= edges; k++) begin
      foreach (sw_edge[i]) if (sw_edge[i] == k) m = sw_m[i];
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (slow_clock !== e.slow || tick !== e.tck) begin
        n_fail++;
        $display("FAIL %s edge%0d: slow=%b tick=%b, required %b %b",
                 name, k, slow_clock, tick, e.slow, e.tck);
      end
    end
  endtask

  task automatic test_reset();
    m = 32'd3;
    do_reset(5);
    check_pattern("m3_after_reset", 3, 20);
  endtask

  task automatic test_m0();
    m = 32'd0;
    do_reset(2);
    check_pattern("m0_every_edge", 0, 10);
  endtask

  task automatic test_m1();
    m = 32'd1;
    do_reset(2);
    check_pattern("m1_pattern", 1, 12);
  endtask

  task automatic test_m_change();
    int unsigned tg[$];
    int unsigned se[$];
    logic [31:0] sm[$];
    m = 32'd9;
    do_reset(2);
    tg = '{8, 13, 18, 28, 38};
    se = '{8, 19};
    sm = '{32'd4, 32'd9};
    check_schedule("m9_to_4_to_9", 40, tg, se, sm);
  endtask

  task automatic test_large_m_reduce();
    int unsigned tg[$];
    int unsigned se[$];
    logic [31:0] sm[$];
    m = 32'h1E847;
    do_reset(2);
    // count is 12 when m drops to 2, so edge 13 must wrap immediately
    tg = '{13, 16, 19};
    se = '{13};
    sm = '{32'd2};
    check_schedule("big_m_drop", 20, tg, se, sm);
  endtask

  task automatic test_all_ones();
    int unsigned tg[$];
    int unsigned se[$];
    logic [31:0] sm[$];
    m = '1;
    do_reset(2);
    tg = '{};
    se = '{};
    sm = '{};
    check_schedule("m_all_ones", 30, tg, se, sm);
    n_checks++;
    if (dut.count !== 32'd30) begin
      n_fail++;
      $display("FAIL all_ones_count: count=%0d, required 30", dut.count);
    end
  endtask

  task automatic test_async_reset();
    m = 32'd3;
    do_reset(2);
    check_pattern("pre_async", 3, 4);
    // slow_clock=1 and tick=1 right after edge 4; drop reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (slow_clock !== 1'b0 || tick !== 1'b0 || dut.count !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: slow=%b tick=%b count=%0d, required 0 0 0",
               slow_clock, tick, dut.count);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (slow_clock !== 1'b0 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL async_hold cyc%0d: slow=%b tick=%b, required 0 0", i, slow_clock, tick);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_pattern("post_async", 3, 16);
  endtask

  task automatic test_duty();
    int unsigned highs, lows, ticks, rises, misalign;
    logic prev;
    m = 32'd999;
    do_reset(2);
    highs = 0; lows = 0; ticks = 0; rises = 0; misalign = 0;
    prev = 1'b0;
    for (int unsigned k = 0; k < 8000; k++) begin
      @(posedge clk);
      #1;
      if (slow_clock === 1'b1) highs++;
      else lows++;
      if (tick === 1'b1) ticks++;
      if (prev === 1'b0 && slow_clock === 1'b1) rises++;
      if (tick !== (slow_clock ^ prev)) misalign++;
      prev = slow_clock;
    end
    n_checks++;
    if (highs !== 4000 || lows !== 4000) begin
      n_fail++;
      $display("FAIL duty: high=%0d low=%0d, required 4000 4000", highs, lows);
    end
    n_checks++;
    if (ticks !== 8 || rises !== 4) begin
      n_fail++;
      $display("FAIL tick_count: ticks=%0d rises=%0d, required 8 4", ticks, rises);
    end
    n_checks++;
    if (misalign !== 0) begin
      n_fail++;
      $display("FAIL tick_align: misaligned=%0d, required 0", misalign);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    m        = '0;
    test_reset();
    test_m0();
    test_m1();
    test_m_change();
    test_large_m_reduce();
    test_all_ones();
    test_async_reset();
    test_duty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
